// File: rtl/instr_encoder_if.sv
// Command / instruction-byte stream bundle for instr_encoder.
// slave  : the encoder's view (takes commands, drives bytes).
// master : the front end / program-store writer's view.
interface instr_encoder_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_dest;
  logic [2:0] cmd_source;
  logic [1:0] cmd_cond;
  logic [7:0] cmd_imm;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_is_operand;
  logic       err;
  logic       err_clear;
  logic       busy;

  modport slave (
    input  cmd_valid, cmd_dest, cmd_source, cmd_cond, cmd_imm,
    input  out_ready, err_clear,
    output cmd_ready, out_valid, out_byte, out_is_operand, err, busy
  );

  modport master (
    output cmd_valid, cmd_dest, cmd_source, cmd_cond, cmd_imm,
    output out_ready, err_clear,
    input  cmd_ready, out_valid, out_byte, out_is_operand, err, busy
  );
endinterface

// File: rtl/instr_encoder.sv
// nic8 command-to-instruction encoder.
// Buffers move commands in a small FIFO and emits {c1,dest,c0,source}
// opcode bytes, followed by the immediate byte for ROM-immediate sources.
// Optional feature macro: INSTR_ENCODER_CHECK_EN -- drop commands that use
// reserved dest (7) or source (1) encodings and flag them on the sticky err.
module instr_encoder #(
  parameter int FIFO_DEPTH = 2
) (
  input logic            clk,
  input logic            reset,
  instr_encoder_if.slave bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [2:0] dest;
    logic [2:0] source;
    logic [1:0] cond;
    logic [7:0] imm;
  } cmdEntry_t;

  typedef enum logic [1:0] {IDLE, OPCODE, OPERAND} state_t;

  function automatic logic [7:0] encode(input cmdEntry_t e);
    return {e.cond[1], e.dest, e.cond[0], e.source};
  endfunction

  cmdEntry_t         mem [FIFO_DEPTH];
  logic [AW:0]       wrPtr, rdPtr, fillCnt;
  logic [AW-1:0]     rdNextIdx;
  logic              full, empty, accept, reject, pushNow, pop;
  logic              headAvail, nextAvail, advance;
  cmdEntry_t         inEntry, curEntry, headEntry, nextEntry;
  state_t            stateQ, stateD;
  logic              outValidQ, outValidD;
  logic [7:0]        outByteQ, outByteD;
  logic              outIsOpQ, outIsOpD;
  logic              errQ;

  assign inEntry = '{dest: bus.cmd_dest, source: bus.cmd_source,
                     cond: bus.cmd_cond, imm: bus.cmd_imm};

  // Pointer pair with an extra wrap bit: equal = empty, index equal with
  // differing wrap = full.
  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
  assign fillCnt = wrPtr - rdPtr;
  assign accept  = bus.cmd_valid && !full;

`ifdef INSTR_ENCODER_CHECK_EN
  assign reject  = accept && ((bus.cmd_dest == 3'd7) || (bus.cmd_source == 3'd1));
`else
  assign reject  = 1'b0;
`endif

  assign pushNow   = accept && !reject;
  assign rdNextIdx = rdPtr[AW-1:0] + 1'b1;
  assign curEntry  = mem[rdPtr[AW-1:0]];

  // The entry being emitted stays in the FIFO until its last byte is taken.
  // An empty FIFO bypasses the incoming command straight into the output
  // registers so the first byte appears the cycle after the push.
  assign headAvail = !empty || pushNow;
  assign headEntry = empty ? inEntry : curEntry;

  // Entry that follows the current head; with only the head stored, a
  // same-cycle push is forwarded so back-to-back commands leave no bubble.
  assign nextAvail = (fillCnt > (AW+1)'(1)) || ((fillCnt == (AW+1)'(1)) && pushNow);
  assign nextEntry = (fillCnt > (AW+1)'(1)) ? mem[rdNextIdx] : inEntry;

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (pushNow) wrPtr <= wrPtr + 1'b1;
      if (pop)     rdPtr <= rdPtr + 1'b1;
    end
  end

  // FIFO storage (contents are don't-care while the pointers say empty)
  always_ff @(posedge clk) begin
    if (pushNow) mem[wrPtr[AW-1:0]] <= inEntry;
  end

  // Emission FSM next-state and next output-register values
  always_comb begin
    stateD    = stateQ;
    outValidD = outValidQ;
    outByteD  = outByteQ;
    outIsOpD  = outIsOpQ;
    pop       = 1'b0;
    advance   = 1'b0;
    case (stateQ)
      IDLE: begin
        if (headAvail) begin
          stateD    = OPCODE;
          outValidD = 1'b1;
          outByteD  = encode(headEntry);
          outIsOpD  = 1'b0;
        end
      end
      OPCODE: begin
        if (bus.out_ready) begin
          if (curEntry.source == 3'd0) begin
            stateD   = OPERAND;
            outByteD = curEntry.imm;
            outIsOpD = 1'b1;
          end else begin
            pop     = 1'b1;
            advance = 1'b1;
          end
        end
      end
      OPERAND: begin
        if (bus.out_ready) begin
          pop     = 1'b1;
          advance = 1'b1;
        end
      end
      default: stateD = IDLE;
    endcase

    if (advance) begin
      if (nextAvail) begin
        stateD    = OPCODE;
        outValidD = 1'b1;
        outByteD  = encode(nextEntry);
        outIsOpD  = 1'b0;
      end else begin
        stateD    = IDLE;
        outValidD = 1'b0;
        outByteD  = 8'h00;
        outIsOpD  = 1'b0;
      end
    end
  end

  // FSM state and registered output stream
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= IDLE;
      outValidQ <= 1'b0;
      outByteQ  <= 8'h00;
      outIsOpQ  <= 1'b0;
    end else begin
      stateQ    <= stateD;
      outValidQ <= outValidD;
      outByteQ  <= outByteD;
      outIsOpQ  <= outIsOpD;
    end
  end

  // Sticky error flag; a new rejected command beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset)              errQ <= 1'b0;
    else if (reject)        errQ <= 1'b1;
    else if (bus.err_clear) errQ <= 1'b0;
  end

  assign bus.cmd_ready      = !full;
  assign bus.out_valid      = outValidQ;
  assign bus.out_byte       = outByteQ;
  assign bus.out_is_operand = outIsOpQ;
  assign bus.err            = errQ;
  assign bus.busy           = !empty || outValidQ;
endmodule
